// File: rtl/chrono_lap_display.sv
`timescale 1ns/1ps
// chrono_lap_display: debounced-button BCD stopwatch with lap freeze, overflow flag and 7-segment scan.
// Build macro LEADING_ZERO_BLANK_EN blanks leading zero digits at index 3 and above.
module chrono_lap_display #(
  parameter int unsigned CLK_FPGA  = 100000000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_HZ   = 1000,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_start_stop,
  input  logic              btn_lap,
  input  logic              btn_clear,
  output logic              running,
  output logic              lap_active,
  output logic              overflow,
  output logic [7:0]        hex_display,
  output logic [DIGITS-1:0] an
);
  localparam int unsigned PRE_MAX  = CLK_FPGA / TICK_HZ - 1;
  localparam int unsigned PRE_W    = $clog2(PRE_MAX + 1);
  localparam int unsigned SCAN_MAX = CLK_FPGA / SCAN_HZ - 1;
  localparam int unsigned SCAN_W   = (SCAN_MAX > 0) ? $clog2(SCAN_MAX + 1) : 1;
  localparam int unsigned DB_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned IDX_W    = $clog2(DIGITS);
  localparam int unsigned CNT_W    = DIGITS * 4;
  localparam int unsigned B_SS     = 0;
  localparam int unsigned B_LAP    = 1;
  localparam int unsigned B_CLR    = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [2:0]        btn_raw, sync1, sync2, db_lvl, press;
  logic [DB_W-1:0]   db_cnt [3];
  logic [1:0]        state, state_n;
  logic              clear_ev_c, ss_ev_c, lap_ev_c, tick_c, wrap_c, carry;
  logic [PRE_W-1:0]  presc;
  logic [CNT_W-1:0]  count, snapshot, count_inc, disp;
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  scan_idx;
  logic [3:0]        digit;
  logic [6:0]        seg_c;
  logic              dp_n_c, blank;
`ifdef LEADING_ZERO_BLANK_EN
  logic              zero_above;
`endif

  assign btn_raw = {btn_clear, btn_lap, btn_start_stop};

  // Synchronise each button, accept a new level after DB_CYCLES stable cycles, pulse on press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      db_lvl <= '0;
      press  <= '0;
      for (int b = 0; b < 3; b++) db_cnt[b] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int b = 0; b < 3; b++) begin
        press[b] <= 1'b0;
        if (sync2[b] == db_lvl[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_W'(DB_CYCLES - 1)) begin
          db_cnt[b] <= '0;
          db_lvl[b] <= sync2[b];
          press[b]  <= sync2[b];
        end else begin
          db_cnt[b] <= db_cnt[b] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Event arbitration (clear > start_stop > lap) and next state
  always_comb begin
    clear_ev_c = press[B_CLR] && (state != S_RUN);
    ss_ev_c    = press[B_SS] && !clear_ev_c;
    lap_ev_c   = press[B_LAP] && !clear_ev_c && !press[B_SS];
    tick_c     = (state == S_RUN) && (presc == PRE_W'(PRE_MAX));
    state_n    = state;
    if (clear_ev_c)   state_n = S_IDLE;
    else if (ss_ev_c) state_n = (state == S_RUN) ? S_PAUSE : S_RUN;
  end

  // BCD increment with ripple carry; carry out of the top digit is the wrap
  always_comb begin
    count_inc = count;
    carry     = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (count[i*4 +: 4] == 4'd9) begin
          count_inc[i*4 +: 4] = 4'd0;
        end else begin
          count_inc[i*4 +: 4] = count[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    wrap_c = carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running    <= 1'b0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
      presc      <= '0;
      count      <= '0;
      snapshot   <= '0;
    end else begin
      running <= (state_n == S_RUN);
      if (clear_ev_c) begin
        lap_active <= 1'b0;
        overflow   <= 1'b0;
        presc      <= '0;
        count      <= '0;
        snapshot   <= '0;
      end else begin
        if (state == S_RUN) begin
          if (tick_c) begin
            presc <= '0;
            count <= count_inc;
            if (wrap_c) overflow <= 1'b1;
          end else begin
            presc <= presc + PRE_W'(1);
          end
        end
        if (lap_ev_c) begin
          if (lap_active) begin
            lap_active <= 1'b0;
          end else if (state == S_RUN) begin
            snapshot   <= count;
            lap_active <= 1'b1;
          end
        end
      end
    end
  end

  // Digit select, optional leading-zero blanking, segment and dp decode
  always_comb begin
    disp  = lap_active ? snapshot : count;
    digit = 4'hF;
    blank = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++)
      if (int'(scan_idx) == i) digit = disp[i*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    zero_above = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp[i*4 +: 4] == 4'd0);
      if ((i >= 3) && (int'(scan_idx) == i) && zero_above) blank = 1'b1;
    end
`endif
    seg_c = 7'h7F;
    case (digit)
      4'd0: seg_c = 7'h40;
      4'd1: seg_c = 7'h79;
      4'd2: seg_c = 7'h24;
      4'd3: seg_c = 7'h30;
      4'd4: seg_c = 7'h19;
      4'd5: seg_c = 7'h12;
      4'd6: seg_c = 7'h02;
      4'd7: seg_c = 7'h78;
      4'd8: seg_c = 7'h00;
      4'd9: seg_c = 7'h10;
      default: seg_c = 7'h7F;
    endcase
    if (blank) seg_c = 7'h7F;
    dp_n_c = !((DIGITS >= 3) && (int'(scan_idx) == 2));
  end

  // Scan timer and registered anode/segment drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      scan_idx    <= '0;
      an          <= '1;
      hex_display <= 8'hFF;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_MAX)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      an          <= ~(DIGITS'(1) << scan_idx);
      hex_display <= {dp_n_c, seg_c};
    end
  end

endmodule

// File: tb/tb_chrono_lap_display.sv
`timescale 1ns/1ps
// tb_chrono_lap_display: directed scoreboard bench; 4-digit main instance plus a 2-digit instance for wrap.
module tb_chrono_lap_display;
  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ss, btn_lap, btn_clr;
  logic       running, lap_active, overflow;
  logic [7:0] hex_display;
  logic [3:0] an;
  logic       ss2, lap2, clr2;
  logic       running2, lap_active2, overflow2;
  logic [7:0] hex2;
  logic [1:0] an2;

  int checks = 0;
  int errors = 0;
  int now = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] D3_ZERO = 8'hFF;
`else
  localparam logic [7:0] D3_ZERO = 8'hC0;
`endif

  always #5 clk = ~clk;

  chrono_lap_display #(
    .CLK_FPGA(1000), .TICK_HZ(100), .DIGITS(4), .SCAN_HZ(250), .DB_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_start_stop(btn_ss), .btn_lap(btn_lap), .btn_clear(btn_clr),
    .running(running), .lap_active(lap_active), .overflow(overflow),
    .hex_display(hex_display), .an(an)
  );

  chrono_lap_display #(
    .CLK_FPGA(1000), .TICK_HZ(100), .DIGITS(2), .SCAN_HZ(250), .DB_CYCLES(4)
  ) u_ovf (
    .clk(clk), .rst(rst),
    .btn_start_stop(ss2), .btn_lap(lap2), .btn_clear(clr2),
    .running(running2), .lap_active(lap_active2), .overflow(overflow2),
    .hex_display(hex2), .an(an2)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_v(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic observe(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) clk1();
  endtask

  // m = {clear, lap, start_stop} on the main instance, o = {clear, start_stop} on the wrap instance.
  // Returns 1ns after the edge on which the FSM acts on the press.
  task automatic press(input logic [2:0] m, input logic [1:0] o);
    @(negedge clk);
    {btn_clr, btn_lap, btn_ss} = m;
    {clr2, ss2} = o;
    step(7);
    {btn_clr, btn_lap, btn_ss} = 3'b000;
    {clr2, ss2} = 2'b00;
  endtask

  task automatic sync_scan(output logic ok);
    int n;
    n = 0;
    while (an == 4'b1110 && n < 32) begin clk1(); n++; end
    while (an != 4'b1110 && n < 64) begin clk1(); n++; end
    ok = (an == 4'b1110);
  endtask

  function automatic int seg_digit(input logic [6:0] s);
    case (s)
      7'h40, 7'h7F: return 0;
      7'h79: return 1;
      7'h24: return 2;
      7'h30: return 3;
      7'h19: return 4;
      7'h12: return 5;
      7'h02: return 6;
      7'h78: return 7;
      7'h00: return 8;
      7'h10: return 9;
      default: return 15;
    endcase
  endfunction

  task automatic read_display(output int val);
    logic ok;
    int mult;
    sync_scan(ok);
    expect_v("read_scan_sync", 32'd1);
    observe(32'(ok));
    val = 0;
    mult = 1;
    for (int i = 0; i < 4; i++) begin
      val += seg_digit(hex_display[6:0]) * mult;
      mult *= 10;
      step(4);
    end
  endtask

  function automatic int live(input int k);
    return 37 + (k + 6) / 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  initial begin
    int   r0, a0, b0, o0, v, lo, hi;
    logic ok;
    rst = 1'b1;
    {btn_ss, btn_lap, btn_clr} = 3'b000;
    {ss2, lap2, clr2} = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    expect_v("rst_running", 32'd0);    observe(32'(running));
    expect_v("rst_lap", 32'd0);        observe(32'(lap_active));
    expect_v("rst_overflow", 32'd0);   observe(32'(overflow));
    expect_v("rst_an", 32'hF);         observe(32'(an));
    expect_v("rst_hex", 32'hFF);       observe(32'(hex_display));
    expect_v("rst_an2", 32'h3);        observe(32'(an2));
    @(negedge clk);
    rst = 1'b0;
    clk1();
    expect_v("scan_first", {20'h0, 4'b1110, 8'hC0});
    observe({20'h0, an, hex_display});

    // Bouncing start_stop, then a clean hold
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      btn_ss = ~btn_ss;
      clk1();
      clk1();
    end
    expect_v("bounce_no_start", 32'd0); observe(32'(running));
    @(negedge clk);
    btn_ss = 1'b1;
    step(6);
    expect_v("start_not_early", 32'd0); observe(32'(running));
    clk1();
    expect_v("start_at_7", 32'd1);      observe(32'(running));
    r0 = now;
    step(5);
    btn_ss = 1'b0;
    step(20);
    expect_v("release_no_event", 32'd1); observe(32'(running));

    // Pause after 376 run cycles: 37 ticks, prescaler left at 6
    step(r0 + 369 - now);
    press(3'b001, 2'b00);
    expect_v("pause_running", 32'd0);   observe(32'(running));
    expect_v("pause_count", 32'h0037);  observe(32'(dut.count));
    sync_scan(ok);
    expect_v("scan_sync", 32'd1);       observe(32'(ok));
    expect_v("scan_d0", {20'h0, 4'b1110, 8'hF8});
    expect_v("scan_d1", {20'h0, 4'b1101, 8'hB0});
    expect_v("scan_d2_dp", {20'h0, 4'b1011, 8'h40});
    expect_v("scan_d3", {20'h0, 4'b0111, D3_ZERO});
    for (int i = 0; i < 4; i++) begin
      observe({20'h0, an, hex_display});
      step(4);
    end

    // Resume: preserved fractional tick gives an increment 4 cycles in
    step(10);
    press(3'b001, 2'b00);
    a0 = now;
    expect_v("resume_running", 32'd1);  observe(32'(running));
    step(3);
    expect_v("resume_hold", 32'h0037);  observe(32'(dut.count));
    step(1);
    expect_v("resume_inc_4", 32'h0038); observe(32'(dut.count));

    // Lap freeze at 0120 while live runs past 0150
    step(a0 + 821 - now);
    press(3'b010, 2'b00);
    expect_v("lap_set", 32'd1);         observe(32'(lap_active));
    expect_v("lap_count", 32'h0120);    observe(32'(dut.count));
    step(a0 + 1126 - now);
    read_display(v);
    expect_v("lap_frozen", 32'd120);    observe(32'(v));
    expect_v("live_past_150", 32'(to_bcd(live(now - a0)))); observe(32'(dut.count));
    press(3'b010, 2'b00);
    expect_v("lap_clear", 32'd0);       observe(32'(lap_active));
    lo = live(now - a0);
    read_display(v);
    hi = live(now - a0);
    expect_v($sformatf("live_shown_%0d", v), 32'd1);
    observe(32'(v >= lo && v <= hi && v >= 150));

    // Clear ignored in RUN
    step(10);
    press(3'b100, 2'b00);
    expect_v("clr_run_running", 32'd1); observe(32'(running));
    expect_v("clr_run_count", 32'(to_bcd(live(now - a0)))); observe(32'(dut.count));

    // Pause then clear
    step(10);
    press(3'b001, 2'b00);
    expect_v("pause2_running", 32'd0);  observe(32'(running));
    expect_v("pause2_count", 32'(to_bcd(live(now - a0)))); observe(32'(dut.count));
    step(10);
    press(3'b100, 2'b00);
    expect_v("clr_running", 32'd0);     observe(32'(running));
    expect_v("clr_count", 32'd0);       observe(32'(dut.count));
    expect_v("clr_overflow", 32'd0);    observe(32'(overflow));
    step(10);
    press(3'b010, 2'b00);
    expect_v("idle_lap_no_capture", 32'd0); observe(32'(lap_active));

    // Restart from a cleared prescaler: first tick after 10 cycles
    step(10);
    press(3'b001, 2'b00);
    b0 = now;
    expect_v("restart_running", 32'd1); observe(32'(running));
    step(9);
    expect_v("restart_pre_tick", 32'd0); observe(32'(dut.count));
    step(1);
    expect_v("restart_tick", 32'd1);    observe(32'(dut.count));
    step(20);
    press(3'b001, 2'b00);
    expect_v("pause3_count", 32'(to_bcd((now - b0) / 10))); observe(32'(dut.count));
    step(10);
    press(3'b101, 2'b00);
    expect_v("simul_running", 32'd0);   observe(32'(running));
    expect_v("simul_count", 32'd0);     observe(32'(dut.count));
    step(20);
    expect_v("simul_stays_idle", 32'd0); observe(32'(running));

    // Wrap on the 2-digit instance: 98 -> 99 -> 00 with sticky overflow
    step(10);
    press(3'b000, 2'b01);
    o0 = now;
    expect_v("ovf_running", 32'd1);     observe(32'(running2));
    step(o0 + 985 - now);
    expect_v("ovf_at_98", 32'h98);      observe(32'(u_ovf.count));
    expect_v("ovf_clear_98", 32'd0);    observe(32'(overflow2));
    step(14);
    expect_v("ovf_at_99", 32'h99);      observe(32'(u_ovf.count));
    expect_v("ovf_clear_99", 32'd0);    observe(32'(overflow2));
    step(1);
    expect_v("ovf_wrap_00", 32'h00);    observe(32'(u_ovf.count));
    expect_v("ovf_set", 32'd1);         observe(32'(overflow2));
    step(50);
    expect_v("ovf_counting", 32'h05);   observe(32'(u_ovf.count));
    expect_v("ovf_sticky", 32'd1);      observe(32'(overflow2));
    press(3'b000, 2'b01);
    expect_v("ovf_pause", 32'd0);       observe(32'(running2));
    expect_v("ovf_sticky_pause", 32'd1); observe(32'(overflow2));
    step(10);
    press(3'b000, 2'b10);
    expect_v("ovf_cleared", 32'd0);     observe(32'(overflow2));
    expect_v("ovf_count_cleared", 32'd0); observe(32'(u_ovf.count));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
